// File: rtl/scpad_types_pkg.sv
// Shared scratchpad types for the SRAM write queue.
// Depth default and request/crossbar descriptors live here.
package scpad_types_pkg;

    localparam int WRQ_DEPTH   = 4;
    localparam int SCPAD_SLOTS = 16;
    localparam int SCPAD_DW    = 8 * SCPAD_SLOTS;

    typedef logic [SCPAD_DW-1:0] scpad_data_t;

    typedef struct packed {
        logic [SCPAD_SLOTS-1:0] slot_mask;
        logic [3:0]             shift;
        logic [SCPAD_SLOTS-1:0] valid_mask;
    } xbar_desc_t;

    typedef struct packed {
        logic        valid;
        scpad_data_t wdata;
        xbar_desc_t  xbar;
    } sram_write_req_t;

    typedef struct packed {
        scpad_data_t wdata;
        xbar_desc_t  xbar;
    } wrq_entry_t;

endpackage

// File: rtl/sram_write_queue_if.sv
// Request-side and SRAM-side signals of the write queue.
// slave = the queue, master = its environment.
interface sram_write_queue_if;
    import scpad_types_pkg::*;

    sram_write_req_t in_req;
    logic            in_ready;
    logic            be_stall;
    logic            sram_wr_en;
    scpad_data_t     sram_wdata;
    xbar_desc_t      sram_xbar;

    modport master (
        output in_req, be_stall,
        input  in_ready, sram_wr_en, sram_wdata, sram_xbar
    );

    modport slave (
        input  in_req, be_stall,
        output in_ready, sram_wr_en, sram_wdata, sram_xbar
    );

endinterface

// File: rtl/scpad_fifo.sv
// Generic pointer/count FIFO; head entry readable combinationally.
// Storage is not reset, only pointers and count.
module scpad_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[head];

    // Power-of-two depth: pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= wdata;
    end

endmodule

// File: rtl/sram_write_queue.sv
// Scratchpad SRAM write queue with sticky overflow flag.
// Optional same-cycle bypass: define SCPAD_WRQ_BYPASS_EN.
module sram_write_queue
    import scpad_types_pkg::*;
#(
    parameter int DEPTH = WRQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_write_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_err,
    input  logic                   err_clr
);

    logic       req_ok;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       byp;
    wrq_entry_t entry_in;
    wrq_entry_t head;

    assign req_ok = bus.in_req.valid
                 && (bus.in_req.xbar.valid_mask != '0);
    assign entry_in = '{wdata: bus.in_req.wdata,
                        xbar:  bus.in_req.xbar};

`ifdef SCPAD_WRQ_BYPASS_EN
    assign byp = req_ok && empty && !bus.be_stall && !rst;
`else
    assign byp = 1'b0;
`endif

    assign bus.in_ready   = !full;
    assign pop            = !empty && !bus.be_stall;
    assign push           = req_ok && !full && !byp;
    assign bus.sram_wr_en = pop || byp;

    always_comb begin
        bus.sram_wdata = '0;
        bus.sram_xbar  = '0;
        if (byp) begin
            bus.sram_wdata = entry_in.wdata;
            bus.sram_xbar  = entry_in.xbar;
        end else if (!empty) begin
            bus.sram_wdata = head.wdata;
            bus.sram_xbar  = head.xbar;
        end
    end

    // A set in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow_err <= 1'b0;
        else if (req_ok && full)
            overflow_err <= 1'b1;
        else if (err_clr)
            overflow_err <= 1'b0;
    end

    scpad_fifo #(
        .WIDTH ($bits(wrq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (entry_in),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_sram_write_queue.sv
// Directed-vector bench for sram_write_queue.
// Expectations follow SCPAD_WRQ_BYPASS_EN where latency differs.
module tb_sram_write_queue;
    import scpad_types_pkg::*;

    localparam int DEPTH = WRQ_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clr;
    logic [CW-1:0] count;
    logic          ovf;
    int            vectors = 0;
    int            miscompares = 0;

    sram_write_queue_if bus ();

    sram_write_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .count        (count),
        .overflow_err (ovf),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    function automatic sram_write_req_t mkreq(input logic [7:0] b,
                                              input logic [15:0] m);
        sram_write_req_t r;
        r.valid           = 1'b1;
        r.wdata           = {16{b}};
        r.xbar.slot_mask  = m;
        r.xbar.shift      = b[3:0];
        r.xbar.valid_mask = m;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        err_clr = 1'b0;
        bus.be_stall = 1'b0;
        bus.in_req = '0;
        tick();
        tick();
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL rst_count: got %0d, expected 0", count); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, expected 1", bus.in_ready); end
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %b, expected 0", bus.sram_wr_en); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b, expected 0", ovf); end
        vectors++; if (bus.sram_wdata !== '0) begin miscompares++; $display("FAIL rst_wdata: got %h, expected 0", bus.sram_wdata); end
        vectors++; if (bus.sram_xbar !== '0) begin miscompares++; $display("FAIL rst_xbar: got %h, expected 0", bus.sram_xbar); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        sram_write_req_t r;
        r = mkreq(8'hA5, 16'hFFFF);
        bus.in_req = r;
        #1;
`ifdef SCPAD_WRQ_BYPASS_EN
        vectors++; if (bus.sram_wr_en !== 1'b1) begin miscompares++; $display("FAIL byp_wr_en: got %b, expected 1", bus.sram_wr_en); end
        vectors++; if (bus.sram_wdata !== r.wdata) begin miscompares++; $display("FAIL byp_wdata: got %h, expected %h", bus.sram_wdata, r.wdata); end
        vectors++; if (bus.sram_xbar !== r.xbar) begin miscompares++; $display("FAIL byp_xbar: got %h, expected %h", bus.sram_xbar, r.xbar); end
        tick();
        bus.in_req = '0;
        #1;
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL byp_count: got %0d, expected 0", count); end
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL byp_wr_en_after: got %b, expected 0", bus.sram_wr_en); end
`else
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_wr_en_early: got %b, expected 0", bus.sram_wr_en); end
        tick();
        bus.in_req = '0;
        #1;
        vectors++; if (bus.sram_wr_en !== 1'b1) begin miscompares++; $display("FAIL single_wr_en: got %b, expected 1", bus.sram_wr_en); end
        vectors++; if (bus.sram_wdata !== r.wdata) begin miscompares++; $display("FAIL single_wdata: got %h, expected %h", bus.sram_wdata, r.wdata); end
        vectors++; if (bus.sram_xbar !== r.xbar) begin miscompares++; $display("FAIL single_xbar: got %h, expected %h", bus.sram_xbar, r.xbar); end
        vectors++; if (count !== 1) begin miscompares++; $display("FAIL single_count: got %0d, expected 1", count); end
        tick();
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL single_wr_en_after: got %b, expected 0", bus.sram_wr_en); end
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL single_count_after: got %0d, expected 0", count); end
`endif
    endtask

    task automatic test_full_overflow;
        scpad_data_t exp;
        bus.be_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_req = mkreq(8'(i), 16'h00F0 | 16'(i));
            tick();
        end
        bus.in_req = '0;
        #1;
        vectors++; if (count !== 4) begin miscompares++; $display("FAIL full_count: got %0d, expected 4", count); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b, expected 0", bus.in_ready); end
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL stall_wr_en: got %b, expected 0", bus.sram_wr_en); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL full_ovf_pre: got %b, expected 0", ovf); end
        bus.in_req = mkreq(8'h05, 16'h0001);
        tick();
        bus.in_req = '0;
        vectors++; if (count !== 4) begin miscompares++; $display("FAIL ovf_count: got %0d, expected 4", count); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b, expected 1", ovf); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b, expected 0", ovf); end
        bus.in_req = mkreq(8'h06, 16'h0002);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        bus.in_req = '0;
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_priority: got %b, expected 1", ovf); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        bus.be_stall = 1'b0;
        bus.in_req = mkreq(8'h09, 16'h0003);
        #1;
        exp = {16{8'h01}};
        vectors++; if (bus.sram_wdata !== exp) begin miscompares++; $display("FAIL drain_wdata_1: got %h, expected %h", bus.sram_wdata, exp); end
        tick();
        bus.in_req = '0;
        vectors++; if (count !== 3) begin miscompares++; $display("FAIL no_passthru_count: got %0d, expected 3", count); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL no_passthru_ovf: got %b, expected 1", ovf); end
        for (int i = 2; i <= 4; i++) begin
            #1;
            exp = {16{8'(i)}};
            vectors++; if (bus.sram_wr_en !== 1'b1) begin miscompares++; $display("FAIL drain_wr_en_%0d: got %b, expected 1", i, bus.sram_wr_en); end
            vectors++; if (bus.sram_wdata !== exp) begin miscompares++; $display("FAIL drain_wdata_%0d: got %h, expected %h", i, bus.sram_wdata, exp); end
            tick();
        end
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL drain_count: got %0d, expected 0", count); end
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL drain_wr_en_end: got %b, expected 0", bus.sram_wr_en); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_zero_mask;
        bus.in_req = mkreq(8'h3C, 16'h0000);
        #1;
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL zmask_wr_en: got %b, expected 0", bus.sram_wr_en); end
        tick();
        bus.in_req = '0;
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL zmask_count: got %0d, expected 0", count); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL zmask_ovf: got %b, expected 0", ovf); end
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL zmask_wr_en_after: got %b, expected 0", bus.sram_wr_en); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  q[$];
        logic [7:0]  hb;
        logic [7:0]  b;
        scpad_data_t exp;
        bus.be_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b = 8'(8'h10 + i);
            bus.in_req = mkreq(b, 16'hFFFF);
            q.push_back(b);
            tick();
        end
        bus.in_req = '0;
        vectors++; if (count !== 2) begin miscompares++; $display("FAIL b2b_count_init: got %0d, expected 2", count); end
        bus.be_stall = 1'b0;
        for (int k = 0; k < 7; k++) begin
            b = 8'(8'h12 + k);
            bus.in_req = mkreq(b, 16'hFFFF);
            #1;
            hb = q[0];
            exp = {16{hb}};
            vectors++; if (bus.sram_wr_en !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_en_%0d: got %b, expected 1", k, bus.sram_wr_en); end
            vectors++; if (bus.sram_wdata !== exp) begin miscompares++; $display("FAIL b2b_wdata_%0d: got %h, expected %h", k, bus.sram_wdata, exp); end
            tick();
            void'(q.pop_front());
            q.push_back(b);
            vectors++; if (count !== 2) begin miscompares++; $display("FAIL b2b_count_%0d: got %0d, expected 2", k, count); end
        end
        bus.in_req = '0;
        for (int k = 0; k < 2; k++) begin
            #1;
            hb = q[0];
            exp = {16{hb}};
            vectors++; if (bus.sram_wdata !== exp) begin miscompares++; $display("FAIL b2b_tail_wdata_%0d: got %h, expected %h", k, bus.sram_wdata, exp); end
            tick();
            void'(q.pop_front());
        end
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL b2b_count_end: got %0d, expected 0", count); end
    endtask

    task automatic test_reset_mid;
        bus.be_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_req = mkreq(8'(8'h20 + i), 16'h0F0F);
            tick();
        end
        bus.in_req = '0;
        vectors++; if (count !== 3) begin miscompares++; $display("FAIL rmid_count_pre: got %0d, expected 3", count); end
        bus.be_stall = 1'b0;
        #1;
        vectors++; if (bus.sram_wr_en !== 1'b1) begin miscompares++; $display("FAIL rmid_wr_en_pre: got %b, expected 1", bus.sram_wr_en); end
        rst = 1'b1;
        #1;
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL rmid_count: got %0d, expected 0", count); end
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL rmid_wr_en: got %b, expected 0", bus.sram_wr_en); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready: got %b, expected 1", bus.in_ready); end
        vectors++; if (bus.sram_wdata !== '0) begin miscompares++; $display("FAIL rmid_wdata: got %h, expected 0", bus.sram_wdata); end
        rst = 1'b0;
        tick();
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL rmid_count_after: got %0d, expected 0", count); end
        vectors++; if (bus.sram_wr_en !== 1'b0) begin miscompares++; $display("FAIL rmid_wr_en_after: got %b, expected 0", bus.sram_wr_en); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overflow();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
